time_entry: RTL and testbench
=============================

// Module: time_entry
// PURPOSE
//  Keypad time-entry stage feeding the countdown digit chain (sec-ones/sec-tens/min-ones/min-tens).
//  Shifts decimal key presses into a 4-digit MM:SS buffer and validates the entry on START.
//  Presents the digits on the chain's data inputs and drives one active-low loadn pulse.
//  Then locks the keypad until the cook controller reports completion.
// PARAMETERS
//  MAX_DIGITS    4  digits accepted per entry (1..4); further digit keys are ignored
//  MAX_SEC_TENS  5  largest legal seconds-tens digit; START with a larger value is rejected
// PORTS
//  clk        in   1  rising-edge clock
//  clr        in   1  asynchronous active-high reset
//  key_valid  in   1  1-cycle strobe: key_code holds a digit key (debounced upstream)
//  key_code   in   4  BCD digit 0..9; values 10..15 are illegal
//  clear_key  in   1  1-cycle strobe: CLEAR pressed
//  start_key  in   1  1-cycle strobe: START pressed
//  done       in   1  1-cycle strobe from cook controller: countdown finished or cancelled
//  sec_ones   out  4  data for seconds-ones digit
//  sec_tens   out  4  data for seconds-tens digit
//  min_ones   out  4  data for minutes-ones digit
//  min_tens   out  4  data for minutes-tens digit
//  loadn      out  1  active-low load strobe to all digits, low for exactly 1 cycle
//  start_req  out  1  1-cycle pulse to cook controller, cycle after loadn low
//  digit_cnt  out  3  number of digits entered (0..MAX_DIGITS)
//  entry_err  out  1  1-cycle pulse on a rejected key or START
// BEHAVIOUR
//  All outputs registered. clr=1 at any time, including mid-LOAD: state=EMPTY, digits=0, digit_cnt=0,
//   loadn=1, start_req=0, entry_err=0. No output glitches on reset release.
//  Priority within one cycle: clear_key > start_key > key_valid. Lower-priority strobes are dropped.
//  FSM states EMPTY, ENTRY, LOAD, LOCKED:
//  EMPTY: legal digit -> shift in, digit_cnt=1, go to ENTRY. start_key -> entry_err pulse, stay.
//   clear_key -> stay.
//  ENTRY: legal digit with digit_cnt<MAX_DIGITS -> shift left:
//   min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_code; digit_cnt+1.
//   digit_cnt==MAX_DIGITS -> digit silently ignored (no error).
//   clear_key -> digits=0, digit_cnt=0, go to EMPTY.
//   start_key with sec_tens>MAX_SEC_TENS -> entry_err pulse, buffer kept, stay in ENTRY.
//   start_key with all four digits zero -> entry_err pulse, stay in ENTRY.
//   Otherwise start_key -> go to LOAD.
//  LOAD: lasts 1 cycle. loadn=0 with stable digits. Next state is LOCKED with start_req=1 for 1 cycle.
//  LOCKED: digit, start and clear strobes ignored with no error. Digits held.
//   done -> digits=0, digit_cnt=0, go to EMPTY.
//  Illegal key_code (>9) with key_valid in EMPTY/ENTRY -> entry_err pulse, buffer unchanged.
//  Leading zero keys are shifted in and counted like any other digit.
//  done outside LOCKED is ignored.
//  Latency: START edge -> loadn low next cycle; start_req the following cycle.
//  Digit outputs stay constant from the LOAD cycle until done.
//  digit_cnt saturates at MAX_DIGITS and never wraps.
// TESTING
//  Keys 1,3,0 then START -> min_ones=1, sec_tens=3, sec_ones=0; loadn low 1 cycle; then start_req pulse.
//  Keys 9,9 then START -> sec_tens=9 > 5 -> entry_err pulse, no loadn, state stays ENTRY.
//  Keys 1,2,3,4,5 -> 5 ignored; buffer 12:34, digit_cnt=4.
//  clear_key and start_key same cycle in ENTRY -> buffer cleared, no loadn, digit_cnt=0.
//  In LOCKED, key 7 and START -> no change, no error; done -> all digits 0, state EMPTY.
//  clr asserted in the LOAD cycle -> loadn returns to 1 at once, no start_req, digits 0.

Source files
------------

// File: rtl/time_entry.sv
// Keypad time-entry stage: shifts BCD keys into an MM:SS buffer, validates on START,
// pulses loadn to the countdown digit chain, then locks until the cook controller reports done.
module time_entry #(
  parameter int unsigned MAX_DIGITS   = 4,
  parameter int unsigned MAX_SEC_TENS = 5
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       clear_key,
  input  logic       start_key,
  input  logic       done,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       loadn,
  output logic       start_req,
  output logic [2:0] digit_cnt,
  output logic       entry_err,
  output logic [1:0] state_dbg
);

  // Handshake: all strobes are single-cycle and sampled on the rising edge; there is no
  // back-pressure. Within one cycle clear_key beats start_key beats key_valid.
  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ENTRY  = 2'd1,
    LOAD   = 2'd2,
    LOCKED = 2'd3
  } state_t;

  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);
  localparam logic [3:0] MAX_ST  = 4'(MAX_SEC_TENS);

  state_t      state_q, state_d;
  logic [15:0] digits_q, digits_d;  // {min_tens, min_ones, sec_tens, sec_ones}
  logic [2:0]  cnt_q, cnt_d;
  logic        loadn_q, loadn_d;
  logic        start_req_q, start_req_d;
  logic        err_q, err_d;
  logic        key_legal;

  assign key_legal = (key_code <= 4'd9);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= EMPTY;
      digits_q    <= '0;
      cnt_q       <= '0;
      loadn_q     <= 1'b1;
      start_req_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      digits_q    <= digits_d;
      cnt_q       <= cnt_d;
      loadn_q     <= loadn_d;
      start_req_q <= start_req_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    digits_d    = digits_q;
    cnt_d       = cnt_q;
    loadn_d     = 1'b1;
    start_req_d = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (clear_key) begin
          state_d = EMPTY;
        end else if (start_key) begin
          err_d = 1'b1;
        end else if (key_valid) begin
          if (!key_legal) begin
            err_d = 1'b1;
          end else begin
            digits_d = {12'h000, key_code};
            cnt_d    = 3'd1;
            state_d  = ENTRY;
          end
        end
      end
      ENTRY: begin
        if (clear_key) begin
          digits_d = '0;
          cnt_d    = '0;
          state_d  = EMPTY;
        end else if (start_key) begin
          if (digits_q[7:4] > MAX_ST || digits_q == 16'h0000) begin
            err_d = 1'b1;
          end else begin
            loadn_d = 1'b0;
            state_d = LOAD;
          end
        end else if (key_valid) begin
          if (!key_legal) begin
            err_d = 1'b1;
          end else if (cnt_q < MAX_CNT) begin
            digits_d = {digits_q[11:0], key_code};
            cnt_d    = cnt_q + 3'd1;
          end
        end
      end
      LOAD: begin
        // loadn is low during this cycle; the controller is told one cycle later.
        start_req_d = 1'b1;
        state_d     = LOCKED;
      end
      LOCKED: begin
        if (done) begin
          digits_d = '0;
          cnt_d    = '0;
          state_d  = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign sec_ones  = digits_q[3:0];
  assign sec_tens  = digits_q[7:4];
  assign min_ones  = digits_q[11:8];
  assign min_tens  = digits_q[15:12];
  assign loadn     = loadn_q;
  assign start_req = start_req_q;
  assign digit_cnt = cnt_q;
  assign entry_err = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_time_entry.sv
// Bench for time_entry: directed scenarios with literal expectations, then random
// keypad traffic checked every cycle against a queue-of-keys reference model.
module tb_time_entry;

  logic       clk = 1'b0;
  logic       clr;
  logic       key_valid, clear_key, start_key, done;
  logic [3:0] key_code;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       loadn, start_req, entry_err;
  logic [2:0] digit_cnt;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;

  time_entry dut (
    .clk(clk), .clr(clr), .key_valid(key_valid), .key_code(key_code),
    .clear_key(clear_key), .start_key(start_key), .done(done),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
    .loadn(loadn), .start_req(start_req), .digit_cnt(digit_cnt),
    .entry_err(entry_err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Buffer = the last keys accepted (oldest first); phase 0 empty, 1 entry, 2 load, 3 locked.
  int keys[$];
  int phase;
  bit e_loadn, e_sr, e_err;

  function automatic int dig(int k);
    if (k < keys.size()) return keys[keys.size() - 1 - k];
    return 0;
  endfunction

  task automatic m_reset();
    keys.delete();
    phase   = 0;
    e_loadn = 1'b1;
    e_sr    = 1'b0;
    e_err   = 1'b0;
  endtask

  task automatic m_step(input bit kv, input int kc, input bit ck, input bit sk, input bit dn);
    e_loadn = 1'b1;
    e_sr    = 1'b0;
    e_err   = 1'b0;
    if (phase == 2) begin
      phase = 3;
      e_sr  = 1'b1;
    end else if (phase == 3) begin
      if (dn) begin
        keys.delete();
        phase = 0;
      end
    end else if (ck) begin
      keys.delete();
      phase = 0;
    end else if (sk) begin
      if (phase == 0) e_err = 1'b1;
      else if (dig(1) > 5) e_err = 1'b1;
      else if (dig(0) + dig(1) + dig(2) + dig(3) == 0) e_err = 1'b1;
      else begin
        phase   = 2;
        e_loadn = 1'b0;
      end
    end else if (kv) begin
      if (kc > 9) e_err = 1'b1;
      else if (keys.size() < 4) begin
        keys.push_back(kc);
        phase = 1;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  bit run_cmp = 1'b0;

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("sec_ones",  int'(sec_ones),  dig(0));
      chk("sec_tens",  int'(sec_tens),  dig(1));
      chk("min_ones",  int'(min_ones),  dig(2));
      chk("min_tens",  int'(min_tens),  dig(3));
      chk("digit_cnt", int'(digit_cnt), keys.size());
      chk("loadn",     int'(loadn),     int'(e_loadn));
      chk("start_req", int'(start_req), int'(e_sr));
      chk("entry_err", int'(entry_err), int'(e_err));
      chk("state",     int'(state_dbg), phase);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit kv, input int kc, input bit ck, input bit sk, input bit dn);
    key_valid = kv;
    key_code  = 4'(kc);
    clear_key = ck;
    start_key = sk;
    done      = dn;
    m_step(kv, kc, ck, sk, dn);
    @(negedge clk);
    #1;
  endtask

  task automatic key(input int kc);
    cyc(1'b1, kc, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clr = 1'b1;
    key_valid = 1'b0; key_code = 4'd0; clear_key = 1'b0; start_key = 1'b0; done = 1'b0;
    m_reset();
    run_cmp = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_loadn", int'(loadn), 1);
    chk("reset_cnt", int'(digit_cnt), 0);
    clr = 1'b0;
    idle();

    // 1,3,0 START -> 01:30 loaded
    key(1); key(3); key(0);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("t1_loadn", int'(loadn), 0);
    chk("t1_min_ones", int'(min_ones), 1);
    chk("t1_sec_tens", int'(sec_tens), 3);
    chk("t1_sec_ones", int'(sec_ones), 0);
    chk("t1_sr_early", int'(start_req), 0);
    idle();
    chk("t1_start_req", int'(start_req), 1);
    chk("t1_loadn_back", int'(loadn), 1);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
    chk("t1_done_cnt", int'(digit_cnt), 0);

    // 9,9 START -> rejected, stays in entry
    key(9); key(9);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("t2_err", int'(entry_err), 1);
    chk("t2_loadn", int'(loadn), 1);
    chk("t2_state", int'(state_dbg), 1);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);

    // 1..5 -> 12:34, fifth ignored; illegal key flagged
    key(1); key(2); key(3); key(4); key(5);
    chk("t3_cnt", int'(digit_cnt), 4);
    chk("t3_mm", int'(min_tens) * 10 + int'(min_ones), 12);
    chk("t3_ss", int'(sec_tens) * 10 + int'(sec_ones), 34);
    chk("t3_no_err", int'(entry_err), 0);
    key(12);
    chk("t3_illegal_err", int'(entry_err), 1);
    chk("t3_illegal_keep", int'(sec_ones), 4);

    // clear and start together -> cleared, no load
    cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
    chk("t4_cnt", int'(digit_cnt), 0);
    chk("t4_loadn", int'(loadn), 1);
    chk("t4_state", int'(state_dbg), 0);

    // zero entry rejected; start in empty rejected
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("t5_empty_start_err", int'(entry_err), 1);
    key(0); key(0);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("t5_zero_err", int'(entry_err), 1);
    chk("t5_zero_cnt", int'(digit_cnt), 2);

    // 0,0,2,0 -> locked; key and start ignored; done clears
    key(2); key(0);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle();
    key(7);
    chk("t6_locked_key", int'(sec_ones), 0);
    chk("t6_locked_noerr", int'(entry_err), 0);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("t6_locked_start", int'(loadn), 1);
    chk("t6_sec_tens_held", int'(sec_tens), 2);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
    chk("t6_done_digits", int'(sec_tens), 0);
    chk("t6_done_state", int'(state_dbg), 0);

    // clr during the LOAD cycle
    key(4); key(5);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("t7_in_load", int'(loadn), 0);
    clr = 1'b1;
    m_reset();
    #1;
    chk("t7_loadn_async", int'(loadn), 1);
    chk("t7_digits_async", int'(sec_ones), 0);
    @(negedge clk);
    #1;
    chk("t7_no_start_req", int'(start_req), 0);
    clr = 1'b0;
    idle();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit kv, ck, sk, dn;
      int kc;
      kv = ($urandom_range(0, 9) < 5);
      kc = (($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 15)));
      ck = ($urandom_range(0, 39) == 0);
      sk = ($urandom_range(0, 9) < 2);
      dn = ($urandom_range(0, 9) == 0);
      cyc(kv, kc, ck, sk, dn);
    end

    run_cmp = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
